range_coalesce_reader: RTL and testbench

- Read-back engine for the AOC5 flow; runs after the final merge pass has left the range list sorted by `first` in the ping or pong bank pair.
- Walks both banks in address order, two pairs per bank read, and coalesces overlapping or adjacent ranges.
- Streams each coalesced range out with a valid/ready handshake and accumulates the total count of covered IDs.
- It is the reader counterpart to the bank-load and merge write path.

---
 rtl/range_coalesce_reader_pkg.sv | 28 ++
 rtl/range_coalesce_reader_if.sv | 31 +++
 rtl/range_coalesce_reader_core.sv | 59 +++++
 rtl/range_coalesce_reader.sv | 175 +++++++++++++++++
 tb/tb_range_coalesce_reader.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/range_coalesce_reader_pkg.sv
// Shared types and helpers for the AOC5 range read-back path.
package range_coalesce_reader_pkg;

    localparam int unsigned DATA_WIDTH          = 8;
    localparam int unsigned BANK_ADDR_WIDTH     = 4;
    localparam int unsigned CNT_WIDTH           = BANK_ADDR_WIDTH + 1;
    localparam int unsigned COUNT_WIDTH_DEFAULT = DATA_WIDTH + BANK_ADDR_WIDTH + 1;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] first;
        logic [DATA_WIDTH-1:0] second;
    } tuple_pair_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_RUN,
        ST_FLUSH,
        ST_DONE
    } reader_state_e;

    // Number of IDs covered by an inclusive range; caller guarantees first <= second.
    function automatic logic [COUNT_WIDTH_DEFAULT-1:0] range_len(input tuple_pair_t p);
        return COUNT_WIDTH_DEFAULT'(p.second) - COUNT_WIDTH_DEFAULT'(p.first)
               + COUNT_WIDTH_DEFAULT'(1);
    endfunction

endpackage

// File: rtl/range_coalesce_reader_if.sv
// Bank-read, range-stream and status signals of the range read-back engine.
interface range_coalesce_reader_if;
    import range_coalesce_reader_pkg::*;

    logic                           start_in;
    logic [CNT_WIDTH-1:0]           pair_count_in;
    logic                           rd_en_out;
    logic [BANK_ADDR_WIDTH-1:0]     rd_addr_out;
    tuple_pair_t                    even_data_in;
    tuple_pair_t                    odd_data_in;
    logic                           range_valid_out;
    logic                           range_ready_in;
    tuple_pair_t                    range_out;
    logic [CNT_WIDTH-1:0]           range_cnt_out;
    logic [COUNT_WIDTH_DEFAULT-1:0] total_out;
    logic                           busy_out;
    logic                           done_out;

    modport slave (
        input  start_in, pair_count_in, even_data_in, odd_data_in, range_ready_in,
        output rd_en_out, rd_addr_out, range_valid_out, range_out, range_cnt_out,
        output total_out, busy_out, done_out
    );

    modport master (
        output start_in, pair_count_in, even_data_in, odd_data_in, range_ready_in,
        input  rd_en_out, rd_addr_out, range_valid_out, range_out, range_cnt_out,
        input  total_out, busy_out, done_out
    );

endinterface

// File: rtl/range_coalesce_reader_core.sv
// Coalescing core: holds the open range and flags when it must be emitted.
module range_coalesce_core
    import range_coalesce_reader_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        clear_i,
    input  logic        in_valid_i,
    input  tuple_pair_t in_pair_i,
    input  logic        flush_i,
    input  logic        stall_i,
    output logic        emit_c_o,
    output tuple_pair_t emit_range_o,
    output logic        cur_valid_o
);

    tuple_pair_t cur_q, cur_d;
    logic        cur_valid_q, cur_valid_d;
    logic        malformed_c, adjacent_c, take_c;

    always_comb begin
        cur_d       = cur_q;
        cur_valid_d = cur_valid_q;
        malformed_c = in_pair_i.first > in_pair_i.second;
        // Extra bit keeps an all-ones second from wrapping to zero.
        adjacent_c  = {1'b0, in_pair_i.first} <= ({1'b0, cur_q.second} + (DATA_WIDTH+1)'(1));
        take_c      = in_valid_i && !malformed_c;
        emit_c_o    = flush_i ? cur_valid_q : (take_c && cur_valid_q && !adjacent_c);

        if (clear_i) begin
            cur_valid_d = 1'b0;
        end else if (!stall_i) begin
            if (flush_i) begin
                cur_valid_d = 1'b0;
            end else if (take_c) begin
                if (cur_valid_q && adjacent_c) begin
                    if (in_pair_i.second > cur_q.second) cur_d.second = in_pair_i.second;
                end else begin
                    cur_d       = in_pair_i;
                    cur_valid_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cur_q       <= '0;
            cur_valid_q <= 1'b0;
        end else begin
            cur_q       <= cur_d;
            cur_valid_q <= cur_valid_d;
        end
    end

    assign emit_range_o = cur_q;
    assign cur_valid_o  = cur_valid_q;

endmodule

// File: rtl/range_coalesce_reader.sv
// Walks the sorted ping/pong bank pair, coalesces ranges and streams them out.
module range_coalesce_reader
    import range_coalesce_reader_pkg::*;
#(
    parameter int unsigned COUNT_WIDTH = COUNT_WIDTH_DEFAULT,
    parameter int unsigned RD_LATENCY  = 1
) (
    input logic                    clock,
    input logic                    reset,
    range_coalesce_reader_if.slave bus_io
);

    if (RD_LATENCY != 1 || COUNT_WIDTH != COUNT_WIDTH_DEFAULT) begin : g_bad_param
        $error("range_coalesce_reader: unsupported RD_LATENCY or COUNT_WIDTH");
    end

    reader_state_e          state_q, state_d;
    logic [CNT_WIDTH-1:0]   count_q, count_d;
    logic [CNT_WIDTH-1:0]   rd_addr_q, rd_addr_d;
    logic                   arr_q, arr_d, arr_ve_q, arr_ve_d, arr_vo_q, arr_vo_d;
    tuple_pair_t            buf_even_q, buf_even_d, buf_odd_q, buf_odd_d;
    logic                   bv_even_q, bv_even_d, bv_odd_q, bv_odd_d;
    tuple_pair_t            out_q, out_d;
    logic                   out_v_q, out_v_d;
    logic [COUNT_WIDTH-1:0] total_q, total_d;
    logic [CNT_WIDTH-1:0]   rcnt_q, rcnt_d;

    logic        slot_ve_c, slot_vo_c, in_valid_c, flush_c, start_ok_c;
    tuple_pair_t slot_even_c, slot_odd_c, in_pair_c;
    logic        emit_c, cur_valid, stall_c, consume_c, last_c, addr_left_c, load_c, rd_en_c;
    tuple_pair_t emit_range;

    // Slot select: on the cycle after a read the bank outputs act as the buffer.
    always_comb begin
        slot_ve_c   = arr_q ? arr_ve_q : bv_even_q;
        slot_vo_c   = arr_q ? arr_vo_q : bv_odd_q;
        slot_even_c = arr_q ? bus_io.even_data_in : buf_even_q;
        slot_odd_c  = arr_q ? bus_io.odd_data_in  : buf_odd_q;
        in_valid_c  = (state_q == ST_RUN) && (slot_ve_c || slot_vo_c);
        in_pair_c   = slot_ve_c ? slot_even_c : slot_odd_c;
        flush_c     = (state_q == ST_FLUSH);
        start_ok_c  = (state_q == ST_IDLE) && bus_io.start_in;
    end

    range_coalesce_core u_core (
        .clock        (clock),
        .reset        (reset),
        .clear_i      (start_ok_c),
        .in_valid_i   (in_valid_c),
        .in_pair_i    (in_pair_c),
        .flush_i      (flush_c),
        .stall_i      (stall_c),
        .emit_c_o     (emit_c),
        .emit_range_o (emit_range),
        .cur_valid_o  (cur_valid)
    );

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        rd_addr_d  = rd_addr_q;
        arr_d      = 1'b0;
        arr_ve_d   = arr_ve_q;
        arr_vo_d   = arr_vo_q;
        buf_even_d = buf_even_q;
        buf_odd_d  = buf_odd_q;
        out_d      = out_q;
        out_v_d    = out_v_q;
        total_d    = total_q;
        rcnt_d     = rcnt_q;
        rd_en_c    = 1'b0;

        stall_c     = emit_c && out_v_q && !bus_io.range_ready_in;
        consume_c   = in_valid_c && !stall_c;
        last_c      = consume_c && !(slot_ve_c && slot_vo_c);
        addr_left_c = rd_addr_q < count_q;
        load_c      = emit_c && !stall_c;

        // Arriving bank words are always captured so a stall cannot lose them.
        if (arr_q) begin
            buf_even_d = bus_io.even_data_in;
            buf_odd_d  = bus_io.odd_data_in;
        end
        bv_even_d = slot_ve_c && !(consume_c && slot_ve_c);
        bv_odd_d  = slot_vo_c && !(consume_c && !slot_ve_c);

        if (bus_io.range_ready_in) out_v_d = 1'b0;
        if (load_c) begin
            out_d   = emit_range;
            out_v_d = 1'b1;
            total_d = total_q + COUNT_WIDTH'(range_len(emit_range));
            rcnt_d  = rcnt_q + CNT_WIDTH'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (start_ok_c) begin
                    count_d   = bus_io.pair_count_in;
                    total_d   = '0;
                    rcnt_d    = '0;
                    rd_addr_d = '0;
                    bv_even_d = 1'b0;
                    bv_odd_d  = 1'b0;
                    state_d   = (bus_io.pair_count_in == '0) ? ST_DONE : ST_FETCH;
                end
            end
            ST_FETCH: begin
                rd_en_c = 1'b1;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (last_c) begin
                    if (addr_left_c) rd_en_c = 1'b1;
                    else             state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (!cur_valid && (!out_v_q || bus_io.range_ready_in)) state_d = ST_DONE;
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        if (rd_en_c) begin
            rd_addr_d = rd_addr_q + CNT_WIDTH'(2);
            arr_d     = 1'b1;
            arr_ve_d  = rd_addr_q < count_q;
            arr_vo_d  = (rd_addr_q + CNT_WIDTH'(1)) < count_q;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            count_q    <= '0;
            rd_addr_q  <= '0;
            arr_q      <= 1'b0;
            arr_ve_q   <= 1'b0;
            arr_vo_q   <= 1'b0;
            buf_even_q <= '0;
            buf_odd_q  <= '0;
            bv_even_q  <= 1'b0;
            bv_odd_q   <= 1'b0;
            out_q      <= '0;
            out_v_q    <= 1'b0;
            total_q    <= '0;
            rcnt_q     <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            rd_addr_q  <= rd_addr_d;
            arr_q      <= arr_d;
            arr_ve_q   <= arr_ve_d;
            arr_vo_q   <= arr_vo_d;
            buf_even_q <= buf_even_d;
            buf_odd_q  <= buf_odd_d;
            bv_even_q  <= bv_even_d;
            bv_odd_q   <= bv_odd_d;
            out_q      <= out_d;
            out_v_q    <= out_v_d;
            total_q    <= total_d;
            rcnt_q     <= rcnt_d;
        end
    end

    assign bus_io.rd_en_out       = rd_en_c;
    assign bus_io.rd_addr_out     = rd_addr_q[BANK_ADDR_WIDTH-1:0];
    assign bus_io.range_valid_out = out_v_q;
    assign bus_io.range_out       = out_q;
    assign bus_io.range_cnt_out   = rcnt_q;
    assign bus_io.total_out       = total_q;
    assign bus_io.busy_out        = (state_q == ST_FETCH) || (state_q == ST_RUN) || (state_q == ST_FLUSH);
    assign bus_io.done_out        = (state_q == ST_DONE);

endmodule

// File: tb/tb_range_coalesce_reader.sv
// Scoreboard bench for range_coalesce_reader with a one-cycle-latency bank model.
module tb_range_coalesce_reader;
    import range_coalesce_reader_pkg::*;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    range_coalesce_reader_if bus();

    range_coalesce_reader dut (
        .clock  (clock),
        .reset  (reset),
        .bus_io (bus)
    );

    int checks = 0;
    int errors = 0;

    tuple_pair_t mem_even [16];
    tuple_pair_t mem_odd  [16];
    int          pf [16];
    int          ps [16];
    tuple_pair_t exp_q [$];
    tuple_pair_t garbage;

    // Bank model: data valid only the cycle after a read, junk otherwise.
    always @(posedge clock) begin
        if (bus.rd_en_out) begin
            bus.even_data_in <= mem_even[bus.rd_addr_out];
            bus.odd_data_in  <= mem_odd[bus.rd_addr_out];
        end else begin
            bus.even_data_in <= garbage;
            bus.odd_data_in  <= garbage;
        end
    end

    task automatic set_pair(input int i, input int f, input int s);
        pf[i] = f;
        ps[i] = s;
    endtask

    task automatic load_list(input int n);
        tuple_pair_t p;
        for (int i = 0; i < 16; i++) begin
            mem_even[i] = garbage;
            mem_odd[i]  = garbage;
        end
        for (int e = 0; e < n; e++) begin
            p.first  = DATA_WIDTH'(pf[e]);
            p.second = DATA_WIDTH'(ps[e]);
            if (e % 2 == 0) mem_even[e] = p;
            else            mem_odd[e - 1] = p;
        end
    endtask

    task automatic run_pass(input string name, input int n, input int mode, input bit poke);
        int cf, cs, exp_total, exp_cnt, exp_addr, reads, cyc, last_xfer, done_cyc, want_done;
        bit have, prev_hold;
        tuple_pair_t t, want, prev_range;
        int d_total, d_cnt, d_busy;

        exp_q.delete();
        have = 1'b0;
        exp_total = 0;
        cf = 0;
        cs = 0;
        for (int e = 0; e < n; e++) begin
            if (pf[e] > ps[e]) continue;
            if (!have) begin
                cf = pf[e]; cs = ps[e]; have = 1'b1;
            end else if (pf[e] <= cs + 1) begin
                if (ps[e] > cs) cs = ps[e];
            end else begin
                t.first = DATA_WIDTH'(cf); t.second = DATA_WIDTH'(cs);
                exp_q.push_back(t);
                exp_total += cs - cf + 1;
                cf = pf[e]; cs = ps[e];
            end
        end
        if (have) begin
            t.first = DATA_WIDTH'(cf); t.second = DATA_WIDTH'(cs);
            exp_q.push_back(t);
            exp_total += cs - cf + 1;
        end
        exp_cnt = exp_q.size();

        @(negedge clock);
        bus.start_in      = 1'b1;
        bus.pair_count_in = CNT_WIDTH'(n);
        bus.range_ready_in = 1'b1;
        @(negedge clock);
        bus.start_in = 1'b0;

        cyc = 0; done_cyc = -1; last_xfer = -1; prev_hold = 1'b0;
        exp_addr = 0; reads = 0; d_total = 0; d_cnt = 0; d_busy = 0;
        prev_range = '0;
        while (cyc < 500 && done_cyc < 0) begin
            bus.range_ready_in = (mode == 0) ? 1'b1 : (cyc % 3 == 0);
            bus.start_in       = poke && (cyc == 3);
            bus.pair_count_in  = (poke && cyc == 3) ? CNT_WIDTH'(1) : CNT_WIDTH'(n);
            #1;
            if (prev_hold) begin
                checks++;
                if (!bus.range_valid_out || bus.range_out !== prev_range) begin
                    errors++;
                    $display("FAIL %s hold cyc %0d got v=%0b (%0d,%0d) want v=1 (%0d,%0d)", name, cyc,
                             bus.range_valid_out, bus.range_out.first, bus.range_out.second,
                             prev_range.first, prev_range.second);
                end
            end
            if (bus.rd_en_out) begin
                checks++;
                if (bus.rd_addr_out !== BANK_ADDR_WIDTH'(exp_addr) || exp_addr >= n) begin
                    errors++;
                    $display("FAIL %s rd_addr got %0d want %0d (count %0d)", name, bus.rd_addr_out, exp_addr, n);
                end
                exp_addr += 2;
                reads++;
            end
            if (bus.range_valid_out && bus.range_ready_in) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL %s extra range got (%0d,%0d) want none", name,
                             bus.range_out.first, bus.range_out.second);
                end else begin
                    want = exp_q.pop_front();
                    if (bus.range_out !== want) begin
                        errors++;
                        $display("FAIL %s range got (%0d,%0d) want (%0d,%0d)", name,
                                 bus.range_out.first, bus.range_out.second, want.first, want.second);
                    end
                end
                last_xfer = cyc;
            end
            prev_hold  = bus.range_valid_out && !bus.range_ready_in;
            prev_range = bus.range_out;
            if (bus.done_out) begin
                done_cyc = cyc;
                d_total  = int'(bus.total_out);
                d_cnt    = int'(bus.range_cnt_out);
                d_busy   = int'(bus.busy_out);
            end
            @(negedge clock);
            cyc++;
        end
        bus.start_in = 1'b0;
        #1;

        checks++;
        if (done_cyc < 0) begin
            errors++;
            $display("FAIL %s done timeout got none want pulse within 500 cycles", name);
        end else begin
            want_done = (exp_cnt == 0) ? 0 : last_xfer + 1;
            checks += 4;
            if (done_cyc != want_done) begin
                errors++;
                $display("FAIL %s done cycle got %0d want %0d", name, done_cyc, want_done);
            end
            if (d_total != exp_total) begin
                errors++;
                $display("FAIL %s total got %0d want %0d", name, d_total, exp_total);
            end
            if (d_cnt != exp_cnt) begin
                errors++;
                $display("FAIL %s range_cnt got %0d want %0d", name, d_cnt, exp_cnt);
            end
            if (d_busy != 0) begin
                errors++;
                $display("FAIL %s busy at done got %0d want 0", name, d_busy);
            end
        end
        checks += 3;
        if (bus.done_out !== 1'b0 || bus.busy_out !== 1'b0) begin
            errors++;
            $display("FAIL %s after done got done=%0b busy=%0b want 0 0", name, bus.done_out, bus.busy_out);
        end
        if (bus.total_out !== COUNT_WIDTH_DEFAULT'(exp_total)) begin
            errors++;
            $display("FAIL %s total hold got %0d want %0d", name, bus.total_out, exp_total);
        end
        if (exp_q.size() != 0 || reads != (n + 1) / 2) begin
            errors++;
            $display("FAIL %s leftovers got missing=%0d reads=%0d want 0 %0d", name, exp_q.size(), reads, (n + 1) / 2);
        end
    endtask

    task automatic check_idle_outputs(input string name);
        #1;
        checks++;
        if (bus.range_valid_out !== 1'b0 || bus.busy_out !== 1'b0 || bus.done_out !== 1'b0 ||
            bus.total_out !== '0 || bus.range_cnt_out !== '0 || bus.rd_en_out !== 1'b0 ||
            bus.rd_addr_out !== '0 || bus.range_out !== '0) begin
            errors++;
            $display("FAIL %s outputs got v=%0b busy=%0b done=%0b total=%0d cnt=%0d rd_en=%0b addr=%0d want all 0",
                     name, bus.range_valid_out, bus.busy_out, bus.done_out, bus.total_out,
                     bus.range_cnt_out, bus.rd_en_out, bus.rd_addr_out);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.start_in = 1'b0;
        bus.pair_count_in = '0;
        bus.range_ready_in = 1'b0;
        repeat (3) @(negedge clock);
        check_idle_outputs("reset");
        reset = 1'b0;
    endtask

    task automatic test_basic_merge();
        set_pair(0, 3, 5); set_pair(1, 10, 14); set_pair(2, 12, 18); set_pair(3, 16, 20);
        load_list(4);
        run_pass("basic", 4, 0, 1'b0);
    endtask

    task automatic test_odd_count();
        set_pair(0, 1, 2); set_pair(1, 3, 4); set_pair(2, 9, 9);
        load_list(3);
        mem_odd[2].first  = DATA_WIDTH'(0);
        mem_odd[2].second = DATA_WIDTH'(100);
        run_pass("odd_count", 3, 0, 1'b0);
    endtask

    task automatic test_zero_count();
        load_list(0);
        run_pass("zero", 0, 0, 1'b0);
    endtask

    task automatic test_backpressure();
        set_pair(0, 1, 1); set_pair(1, 3, 4); set_pair(2, 6, 8);
        set_pair(3, 10, 10); set_pair(4, 20, 30); set_pair(5, 40, 41);
        load_list(6);
        run_pass("backpressure", 6, 1, 1'b0);
    endtask

    task automatic test_max_value();
        set_pair(0, 0, (1 << DATA_WIDTH) - 1); set_pair(1, 5, 7);
        load_list(2);
        run_pass("max_value", 2, 0, 1'b0);
    endtask

    task automatic test_malformed();
        set_pair(0, 2, 4); set_pair(1, 9, 1); set_pair(2, 5, 6);
        load_list(3);
        run_pass("malformed", 3, 0, 1'b0);
    endtask

    task automatic test_start_ignored();
        set_pair(0, 3, 5); set_pair(1, 10, 14); set_pair(2, 12, 18); set_pair(3, 16, 20);
        load_list(4);
        run_pass("start_busy", 4, 0, 1'b1);
    endtask

    task automatic test_reset_mid_pass();
        set_pair(0, 1, 1); set_pair(1, 3, 4); set_pair(2, 6, 8);
        set_pair(3, 10, 10); set_pair(4, 20, 30); set_pair(5, 40, 41);
        load_list(6);
        @(negedge clock);
        bus.range_ready_in = 1'b0;
        bus.start_in = 1'b1;
        bus.pair_count_in = CNT_WIDTH'(6);
        @(negedge clock);
        bus.start_in = 1'b0;
        repeat (6) @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        check_idle_outputs("reset_mid");
        reset = 1'b0;
        set_pair(0, 4, 6); set_pair(1, 8, 9);
        load_list(2);
        run_pass("after_reset", 2, 0, 1'b0);
    endtask

    initial begin
        garbage.first  = DATA_WIDTH'(8'hF0);
        garbage.second = DATA_WIDTH'(8'hF8);
        test_reset();
        test_basic_merge();
        test_odd_count();
        test_zero_count();
        test_backpressure();
        test_max_value();
        test_malformed();
        test_start_ignored();
        test_reset_mid_pass();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
